turfio_hdr_mask_gen: RTL and testbench

- Per-TURFIO header conditioner. Sits directly upstream of the header accumulator, one instance per TURFIO stream (hdr0..hdr3).
- Unmasked: passes the real TURFIO header stream through whole frames.
- Masked: discards real input and synthesizes a fixed 4-beat, 64-bit fake header frame for every TURF header event. The accumulator always receives one TURFIO header frame per event.

---
 rtl/turfio_hdr_mask_gen.sv | 142 ++++++++++++++
 tb/tb_turfio_hdr_mask_gen.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turfio_hdr_mask_gen.sv
// Per-TURFIO header conditioner: passes real header frames, or when masked drops them and
// emits one synthetic FAKE_BEATS-beat frame per TURF header event. Optional stats: TURFIO_HDR_STAT_EN.
module turfio_hdr_mask_gen #(
  parameter int TIO_INDEX  = 0,
  parameter int PEND_BITS  = 4,
  parameter int FAKE_BEATS = 4
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        mask_i,
  input  logic        thdr_evt_i,
  input  logic [63:0] s_hdr_tdata,
  input  logic        s_hdr_tvalid,
  output logic        s_hdr_tready,
  input  logic        s_hdr_tlast,
  output logic [63:0] m_hdr_tdata,
  output logic        m_hdr_tvalid,
  input  logic        m_hdr_tready,
  output logic        m_hdr_tlast,
  output logic        pend_ovf_o
`ifdef TURFIO_HDR_STAT_EN
  ,
  output logic [15:0] fake_cnt_o,
  output logic [15:0] drop_cnt_o
`endif
);

  // state | meaning
  // IDLE  | between frames, mode chosen from mask_q / pending / s_hdr_tvalid
  // PASS  | real frame forwarded combinationally
  // FAKE  | synthetic frame emitted from registers
  // DROP  | real frame consumed and discarded
  typedef enum logic [1:0] {IDLE, PASS, FAKE, DROP} state_t;

  localparam logic [PEND_BITS-1:0] PEND_MAX  = '1;
  localparam logic [3:0]           LAST_BEAT = 4'(FAKE_BEATS - 1);
  localparam logic [1:0]           TIO_ID    = 2'(TIO_INDEX);

  state_t               state, state_nxt;
  logic                 mask_q;
  logic [PEND_BITS-1:0] pending;
  logic [31:0]          evtnum;
  logic [3:0]           beat;
  logic                 fake_hs, fake_done, pend_inc, pend_dec;
  logic [63:0]          fake_data;

  assign fake_hs   = (state == FAKE) && m_hdr_tready;
  assign fake_done = fake_hs && (beat == LAST_BEAT);
  assign pend_inc  = thdr_evt_i && mask_q;
  assign pend_dec  = fake_done;
  assign fake_data = {8'hFA, 6'd0, TIO_ID, 4'd0, beat, 8'd0, evtnum};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state  <= IDLE;
      mask_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      mask_q <= mask_i;
    end
  end

  // Mode is only chosen in IDLE, so a mask change lands on a frame boundary.
  always_comb begin
    state_nxt    = state;
    m_hdr_tdata  = '0;
    m_hdr_tvalid = 1'b0;
    m_hdr_tlast  = 1'b0;
    s_hdr_tready = 1'b0;
    case (state)
      IDLE: begin
        if (!mask_q) begin
          if (s_hdr_tvalid) state_nxt = PASS;
        end else if (pending != '0) begin
          state_nxt = FAKE;
        end else if (s_hdr_tvalid) begin
          state_nxt = DROP;
        end
      end
      PASS: begin
        m_hdr_tdata  = s_hdr_tdata;
        m_hdr_tvalid = s_hdr_tvalid;
        m_hdr_tlast  = s_hdr_tlast;
        s_hdr_tready = m_hdr_tready;
        if (s_hdr_tvalid && m_hdr_tready && s_hdr_tlast) state_nxt = IDLE;
      end
      FAKE: begin
        m_hdr_tdata  = fake_data;
        m_hdr_tvalid = 1'b1;
        m_hdr_tlast  = (beat == LAST_BEAT);
        if (fake_done) state_nxt = IDLE;
      end
      DROP: begin
        s_hdr_tready = 1'b1;
        if (s_hdr_tvalid && s_hdr_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      beat   <= '0;
      evtnum <= '0;
    end else if (fake_hs) begin
      if (fake_done) begin
        beat   <= '0;
        evtnum <= evtnum + 32'd1;
      end else begin
        beat <= beat + 4'd1;
      end
    end
  end

  // Unmasked idle discards any backlog; a saturating increment latches the overflow flag.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pending    <= '0;
      pend_ovf_o <= 1'b0;
    end else if ((state == IDLE) && !mask_q) begin
      pending <= '0;
    end else if (pend_inc && !pend_dec) begin
      if (pending == PEND_MAX) pend_ovf_o <= 1'b1;
      else                     pending    <= pending + 1'b1;
    end else if (pend_dec && !pend_inc) begin
      pending <= pending - 1'b1;
    end
  end

`ifdef TURFIO_HDR_STAT_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      fake_cnt_o <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (fake_done) fake_cnt_o <= fake_cnt_o + 16'd1;
      if ((state == DROP) && s_hdr_tvalid && s_hdr_tlast) drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_turfio_hdr_mask_gen.sv
// Bench for turfio_hdr_mask_gen: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_turfio_hdr_mask_gen;
  localparam int TIO = 2;
  localparam int PB  = 2;
  localparam int FB  = 4;
  localparam int PMAX = (1 << PB) - 1;
  localparam int K_IDLE = 0, K_PASS = 1, K_FAKE = 2, K_DROP = 3;

  logic        aclk = 1'b0;
  logic        areset;
  logic        mask_i, thdr_evt_i;
  logic [63:0] s_hdr_tdata;
  logic        s_hdr_tvalid, s_hdr_tready, s_hdr_tlast;
  logic [63:0] m_hdr_tdata;
  logic        m_hdr_tvalid, m_hdr_tready, m_hdr_tlast;
  logic        pend_ovf_o;
`ifdef TURFIO_HDR_STAT_EN
  logic [15:0] fake_cnt, drop_cnt;
`endif

  always #5 aclk = ~aclk;

  turfio_hdr_mask_gen #(.TIO_INDEX(TIO), .PEND_BITS(PB), .FAKE_BEATS(FB)) dut (
    .aclk(aclk), .areset(areset), .mask_i(mask_i), .thdr_evt_i(thdr_evt_i),
    .s_hdr_tdata(s_hdr_tdata), .s_hdr_tvalid(s_hdr_tvalid), .s_hdr_tready(s_hdr_tready),
    .s_hdr_tlast(s_hdr_tlast),
    .m_hdr_tdata(m_hdr_tdata), .m_hdr_tvalid(m_hdr_tvalid), .m_hdr_tready(m_hdr_tready),
    .m_hdr_tlast(m_hdr_tlast),
`ifdef TURFIO_HDR_STAT_EN
    .fake_cnt_o(fake_cnt), .drop_cnt_o(drop_cnt),
`endif
    .pend_ovf_o(pend_ovf_o)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {logic [63:0] data; logic last;} beat_t;
  beat_t out_q[$];

  logic [63:0] frame_d [8];
  logic [63:0] tmp;
  int          cyc;

  // Reference model: frame kind in progress, backlog of events, counters.
  logic        m_mq, m_ovf;
  int          m_pend, m_beat, m_kind, nk, m_fakes, m_drops;
  logic [31:0] m_evt;
  logic        inc, dec;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 64'(act), 64'(exp));
  endtask

  function automatic logic [63:0] fake_word(input int b, input logic [31:0] e);
    return 64'hFA00_0000_0000_0000 | (64'(TIO) << 48) | (64'(b) << 40) | {32'd0, e};
  endfunction

  task automatic model_reset();
    m_mq = 0; m_ovf = 0; m_pend = 0; m_beat = 0; m_kind = K_IDLE;
    m_evt = 0; m_fakes = 0; m_drops = 0;
  endtask

  // Compare + model advance at the falling edge; inputs are stable until the next rising edge.
  initial begin
    model_reset();
    forever begin
      @(negedge aclk);
      if (areset) begin
        model_reset();
      end else begin
        case (m_kind)
          K_PASS: begin
            chk1("pass_tvalid", m_hdr_tvalid, s_hdr_tvalid);
            chk1("pass_tready", s_hdr_tready, m_hdr_tready);
            if (s_hdr_tvalid) begin
              chk("pass_tdata", m_hdr_tdata, s_hdr_tdata);
              chk1("pass_tlast", m_hdr_tlast, s_hdr_tlast);
            end
          end
          K_FAKE: begin
            chk1("fake_tvalid", m_hdr_tvalid, 1'b1);
            chk1("fake_tready", s_hdr_tready, 1'b0);
            chk("fake_tdata", m_hdr_tdata, fake_word(m_beat, m_evt));
            chk1("fake_tlast", m_hdr_tlast, m_beat == FB - 1);
          end
          K_DROP: begin
            chk1("drop_tvalid", m_hdr_tvalid, 1'b0);
            chk1("drop_tready", s_hdr_tready, 1'b1);
          end
          default: begin
            chk1("idle_tvalid", m_hdr_tvalid, 1'b0);
            chk1("idle_tready", s_hdr_tready, 1'b0);
            chk("idle_tdata", m_hdr_tdata, 64'd0);
          end
        endcase
        chk1("pend_ovf", pend_ovf_o, m_ovf);
`ifdef TURFIO_HDR_STAT_EN
        chk("fake_cnt", 64'(fake_cnt), 64'(16'(m_fakes)));
        chk("drop_cnt", 64'(drop_cnt), 64'(16'(m_drops)));
`endif
        if (m_hdr_tvalid && m_hdr_tready) out_q.push_back('{m_hdr_tdata, m_hdr_tlast});

        inc = thdr_evt_i && m_mq;
        dec = (m_kind == K_FAKE) && m_hdr_tready && (m_beat == FB - 1);
        nk = m_kind;
        case (m_kind)
          K_IDLE: begin
            if (!m_mq) begin
              if (s_hdr_tvalid) nk = K_PASS;
            end else if (m_pend > 0) begin
              nk = K_FAKE; m_beat = 0;
            end else if (s_hdr_tvalid) begin
              nk = K_DROP;
            end
          end
          K_PASS: if (s_hdr_tvalid && m_hdr_tready && s_hdr_tlast) nk = K_IDLE;
          K_DROP: if (s_hdr_tvalid && s_hdr_tlast) begin nk = K_IDLE; m_drops++; end
          default: if (m_hdr_tready) begin
            if (m_beat == FB - 1) begin nk = K_IDLE; m_evt = m_evt + 1; m_fakes++; end
            else m_beat++;
          end
        endcase
        if (m_kind == K_IDLE && !m_mq) m_pend = 0;
        else if (inc && !dec) begin
          if (m_pend == PMAX) m_ovf = 1; else m_pend++;
        end else if (dec && !inc) m_pend--;
        m_kind = nk;
        m_mq = mask_i;
      end
    end
  end

  task automatic step();
    @(posedge aclk); #1;
  endtask

  task automatic send_real(input int n, input bit toggle, input int mask_beat, output int ncyc);
    logic hs;
    ncyc = 0;
    for (int i = 0; i < n; i++) begin
      s_hdr_tvalid = 1'b1; s_hdr_tdata = frame_d[i]; s_hdr_tlast = (i == n - 1);
      if (i == mask_beat) mask_i = 1'b1;
      hs = 1'b0;
      for (int t = 0; t < 40 && !hs; t++) begin
        @(negedge aclk); hs = s_hdr_tready;
        @(posedge aclk); #1; ncyc++;
        if (toggle) m_hdr_tready = ~m_hdr_tready;
      end
      chk1("send_handshake", hs, 1'b1);
    end
    s_hdr_tvalid = 1'b0; s_hdr_tlast = 1'b0;
  endtask

  task automatic wait_out(input int n);
    for (int t = 0; t < 200 && out_q.size() < n; t++) step();
    chk1("wait_out", out_q.size() >= n, 1'b1);
  endtask

  task automatic pulse_evt();
    thdr_evt_i = 1'b1; step(); thdr_evt_i = 1'b0; step();
  endtask

  initial begin
    logic hs;
    int   rem;
    areset = 1'b1; mask_i = 0; thdr_evt_i = 0; s_hdr_tdata = '0; s_hdr_tvalid = 0;
    s_hdr_tlast = 0; m_hdr_tready = 1;
    #12;
    chk1("rst_tvalid", m_hdr_tvalid, 1'b0);
    chk1("rst_tlast", m_hdr_tlast, 1'b0);
    chk("rst_tdata", m_hdr_tdata, 64'd0);
    chk1("rst_tready", s_hdr_tready, 1'b0);
    chk1("rst_ovf", pend_ovf_o, 1'b0);
    step(); areset = 1'b0; step();

    // Unmasked pass with toggling downstream ready
    frame_d[0] = 64'h11; frame_d[1] = 64'h22; frame_d[2] = 64'h33;
    out_q.delete();
    send_real(3, 1'b1, -1, cyc);
    m_hdr_tready = 1'b1; step(); step();
    chk("pass_count", 64'(out_q.size()), 64'd3);
    chk("pass_b0", out_q[0].data, 64'h11);
    chk("pass_b2", out_q[2].data, 64'h33);
    chk1("pass_b1_last", out_q[1].last, 1'b0);
    chk1("pass_b2_last", out_q[2].last, 1'b1);

    // Masked: two events -> two fake frames
    mask_i = 1'b1; step(); step();
    out_q.delete();
    pulse_evt(); pulse_evt();
    wait_out(8);
    repeat (10) step();
    chk("fake_count", 64'(out_q.size()), 64'd8);
    chk("fake_f0b0", out_q[0].data, 64'hFA02_0000_0000_0000);
    chk("fake_f0b3", out_q[3].data, 64'hFA02_0300_0000_0000);
    chk1("fake_f0b3_last", out_q[3].last, 1'b1);
    tmp = out_q[4].data;
    chk("fake_f1_low", {32'd0, tmp[31:0]}, 64'd1);

    // Masked drop, no events
    for (int i = 0; i < 4; i++) frame_d[i] = 64'hD0 + 64'(i);
    out_q.delete();
    send_real(4, 1'b0, -1, cyc);
    chk("drop_cycles", 64'(cyc), 64'd5);
    repeat (3) step();
    chk("drop_out_count", 64'(out_q.size()), 64'd0);
`ifdef TURFIO_HDR_STAT_EN
    chk("drop_cnt_lit", 64'(drop_cnt), 64'd1);
`endif

    // Backpressure on a fake frame
    m_hdr_tready = 1'b0;
    pulse_evt();
    out_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk1("bp_tvalid", m_hdr_tvalid, 1'b1);
      chk("bp_tdata", m_hdr_tdata, 64'hFA02_0000_0000_0002);
      step();
    end
    m_hdr_tready = 1'b1;
    wait_out(4);
    repeat (10) step();
    chk("bp_count", 64'(out_q.size()), 64'd4);
    chk("bp_b3", out_q[3].data, 64'hFA02_0300_0000_0002);

    // Pending saturation at 3 with overflow flag
    m_hdr_tready = 1'b0;
    out_q.delete();
    pulse_evt(); pulse_evt(); pulse_evt();
    chk1("ovf_before", pend_ovf_o, 1'b0);
    pulse_evt();
    chk1("ovf_after", pend_ovf_o, 1'b1);
    m_hdr_tready = 1'b1;
    wait_out(12);
    repeat (20) step();
    chk("ovf_count", 64'(out_q.size()), 64'd12);
    chk("ovf_last", out_q[11].data, 64'hFA02_0300_0000_0005);

    // Mask rises mid-frame: frame passes whole, next frame dropped after pending fake
    mask_i = 1'b0; repeat (3) step();
    out_q.delete();
    frame_d[0] = 64'hA1; frame_d[1] = 64'hA2; frame_d[2] = 64'hA3;
    send_real(3, 1'b0, 1, cyc);
    thdr_evt_i = 1'b1; step(); thdr_evt_i = 1'b0;
    frame_d[0] = 64'hB1; frame_d[1] = 64'hB2;
    send_real(2, 1'b0, -1, cyc);
    repeat (10) step();
    chk("mc_count", 64'(out_q.size()), 64'd7);
    chk("mc_b0", out_q[0].data, 64'hA1);
    chk("mc_b2", out_q[2].data, 64'hA3);
    chk("mc_fake", out_q[3].data, 64'hFA02_0000_0000_0006);
    chk1("mc_fake_last", out_q[6].last, 1'b1);
`ifdef TURFIO_HDR_STAT_EN
    chk("mc_fake_cnt", 64'(fake_cnt), 64'd7);
    chk("mc_drop_cnt", 64'(drop_cnt), 64'd2);
`endif

    // Async reset while a fake frame is stalled
    m_hdr_tready = 1'b0;
    pulse_evt();
    @(negedge aclk);
    chk1("prerst_tvalid", m_hdr_tvalid, 1'b1);
    @(posedge aclk); #3;
    areset = 1'b1; #1;
    chk1("midrst_tvalid", m_hdr_tvalid, 1'b0);
    chk1("midrst_ovf", pend_ovf_o, 1'b0);
    step(); areset = 1'b0;
    m_hdr_tready = 1'b1; mask_i = 1'b0;
    repeat (3) step();

    // Randomized traffic, checked cycle by cycle by the model
    rem = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge aclk); hs = s_hdr_tvalid && s_hdr_tready;
      @(posedge aclk); #1;
      if (hs) begin rem--; s_hdr_tvalid = 1'b0; end
      if (!s_hdr_tvalid) begin
        if (rem == 0 && $urandom_range(3) == 0) rem = int'($urandom_range(5, 1));
        if (rem > 0 && $urandom_range(2) != 0) begin
          s_hdr_tvalid = 1'b1; s_hdr_tdata = {$urandom, $urandom}; s_hdr_tlast = (rem == 1);
        end
      end
      m_hdr_tready = ($urandom_range(3) != 0);
      thdr_evt_i   = ($urandom_range(7) == 0);
      if ($urandom_range(63) == 0) mask_i = ~mask_i;
    end
    s_hdr_tvalid = 1'b0; thdr_evt_i = 1'b0; m_hdr_tready = 1'b1;
    repeat (50) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
